// File: rtl/vreg_pkg.sv
// Shared types and sizing for the vector register file writeback path.
package vreg_pkg;

  localparam int unsigned NUM_REGS    = 32;
  localparam int unsigned LANES       = 4;
  localparam int unsigned WIDTH       = 32;
  localparam int unsigned VREG_ADDR_W = 5;

  typedef logic [VREG_ADDR_W-1:0]      vreg_addr_t;
  typedef logic [LANES-1:0][WIDTH-1:0] vlane_t;
  typedef logic [LANES-1:0]            vmask_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  int unsigned cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr_i) + i) % N;
      if (!valid_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = IdxW'(cand);
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vreg_wb_arbiter.sv
// Writeback arbiter for the vector register file: round-robin source select, one
// registered write stage, and a per-register busy scoreboard for RAW stalls.
module vreg_wb_arbiter
  import vreg_pkg::*;
#(
  parameter int unsigned NUM_SRC = 3,
  localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  vreg_addr_t [NUM_SRC-1:0]  src_addr,
  input  vlane_t [NUM_SRC-1:0]      src_data,
  input  vmask_t [NUM_SRC-1:0]      src_mask,
  input  logic                      issue_valid,
  input  vreg_addr_t                issue_addr,
  output vreg_addr_t                write_addr,
  output vlane_t                    write_vector,
  output vmask_t                    we,
  output logic [NUM_REGS-1:0]       busy,
  output logic                      issue_conflict
);

  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_SRC-1:0]  gnt;
  logic [IdxW-1:0]     win;
  logic                gnt_any;

  vreg_addr_t          addr_q, addr_d;
  vlane_t              vec_q, vec_d;
  vmask_t              we_q, we_d;
  logic                commit_q, commit_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                conflict_q, conflict_d;

  rr_arbiter #(
    .N(NUM_SRC)
  ) u_rr_arbiter (
    .req_i  (src_valid),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (gnt),
    .idx_o  (win),
    .valid_o(gnt_any)
  );

  // No grant is visible while reset is held, so nothing upstream thinks it transferred.
  assign src_ready = gnt & {NUM_SRC{rst_n}};

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    vec_d    = vec_q;
    we_d     = '0;
    commit_d = 1'b0;
    if (gnt_any) begin
      rr_ptr_d = (win == IdxW'(NUM_SRC - 1)) ? '0 : win + 1'b1;
      addr_d   = src_addr[win];
      vec_d    = src_data[win];
      we_d     = src_mask[win];
      commit_d = 1'b1;
    end
  end

  // Commit clears first so a same-cycle issue to the same register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (commit_q) begin
      busy_d[addr_q] = 1'b0;
    end
    if (issue_valid) begin
      busy_d[issue_addr] = 1'b1;
    end
    conflict_d = issue_valid && busy_q[issue_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      addr_q     <= '0;
      vec_q      <= '0;
      we_q       <= '0;
      commit_q   <= 1'b0;
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      addr_q     <= addr_d;
      vec_q      <= vec_d;
      we_q       <= we_d;
      commit_q   <= commit_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign write_addr     = addr_q;
  assign write_vector   = vec_q;
  assign we             = we_q;
  assign busy           = busy_q;
  assign issue_conflict = conflict_q;

endmodule

// File: doc/vreg_wb_arbiter.md
# vreg_wb_arbiter

Writeback arbiter and scoreboard for the 32-entry, 4-lane vector register file. Accepts writeback beats from up to NUM_SRC producers (vector ALU, load unit, scalar-to-vector move), picks one per cycle round-robin and drives the register file's single write port through one register stage. Tracks a busy bit per vector register, set at issue and cleared at writeback, so the decoder can stall on read-after-write hazards.

## Interface
- NUM_SRC, 3, number of writeback requesters
- NUM_REGS, 32, vector registers; address width is $clog2(NUM_REGS) = 5
- LANES, 4, lanes per vector register
- WIDTH, 32, bits per lane

Ports:
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset, synchronous, active-low
- src_valid  in  NUM_SRC  per-source writeback request
- src_ready  out  NUM_SRC  per-source grant; a beat transfers when valid && ready
- src_addr  in  NUM_SRC x 5  destination register per source
- src_data  in  NUM_SRC x LANES x WIDTH  lane data per source
- src_mask  in  NUM_SRC x LANES  lane write mask per source
- issue_valid  in  1  decoder issued an instruction that writes a vector register
- issue_addr  in  5  destination of the issued instruction
- write_addr  out  5  to register file write address
- write_vector  out  LANES x WIDTH  to register file write data
- we  out  LANES  to register file per-lane write enable
- busy  out  NUM_REGS  scoreboard; bit r set means a write to register r is outstanding
- issue_conflict  out  1  one-cycle pulse: issue targeted a register that was already busy

## Operation
- Arbitration: round-robin over src_valid, starting at pointer rr_ptr. The winner gets src_ready high in the same cycle, combinationally; all other src_ready are low. With no valid source, all src_ready are low.
- rr_ptr: on a grant to source k, rr_ptr <= (k+1) mod NUM_SRC. It holds when nothing is granted.
- Output stage: an accepted beat is registered into write_addr, write_vector and we = src_mask. There is no backpressure from the register file, so the stage accepts every cycle.
- A cycle with no grant drives we = 0. write_addr and write_vector hold their last values.
- Commit: a registered output beat is a commit whether or not its mask is zero. At the edge ending the commit cycle, busy[write_addr] clears.
- Issue: issue_valid sets busy[issue_addr] at the next edge.
- Issue and commit to the same register in the same cycle: set wins, so busy stays 1 for the new producer.
- Issue to a register whose busy bit is already 1: the bit stays set and issue_conflict pulses for one cycle, registered. The decoder is responsible for not doing this.
- A mask of 0 is legal. It writes nothing but still commits and clears busy.

## Timing
- Request to register-file write: accept in cycle N, we asserted in cycle N+1 for exactly one cycle per beat.
- Busy clear is visible in cycle N+2, after the write edge. Read bypass inside the register file covers cycle N+1.
- Throughput: one beat per cycle. Under full contention each source is granted once every NUM_SRC cycles.
- Any cycle with rst_n = 0 at the edge resets rr_ptr to 0 and clears busy, we, write_addr, write_vector and issue_conflict. src_ready is low while rst_n = 0. A beat in flight when reset is asserted is dropped.
- All outputs are 0 at reset.

## Structure
- Package vreg_pkg holds:
  - NUM_REGS, LANES, WIDTH, VREG_ADDR_W = 5
  - typedef vreg_addr_t
  - typedef vlane_t [LANES-1:0][WIDTH-1:0]
  - typedef vmask_t
- Sub-module rr_arbiter (parameter N): takes the request vector and rr_ptr, returns a one-hot grant plus the winner index. The scoreboard and output stage stay in the top module.

## Test plan
- Single source: src_valid[1] = 1, addr 5, data {4,3,2,1}, mask 4'b1111 -> src_ready[1] high the same cycle; next cycle we = 4'b1111, write_addr = 5, write_vector = {4,3,2,1}.
- Full contention: all sources valid for 6 cycles from reset -> grant order 0,1,2,0,1,2; we high on 6 consecutive cycles.
- Scoreboard: issue addr 7 -> busy[7] = 1 next cycle; source 0 writes addr 7 -> busy[7] = 0 two cycles after the grant.
- Simultaneous: issue addr 9 in the same cycle that a commit to addr 9 is on the write port -> busy[9] stays 1.
- Conflict and mask: issue addr 3 twice on consecutive cycles -> issue_conflict pulses once. A beat with mask 0 to addr 3 -> we = 0, busy[3] clears.
- Reset mid-operation: rst_n low during a cycle with a granted beat and busy = 32'hFFFF_0000 -> next cycle busy = 0, we = 0, rr_ptr = 0, src_ready = 0.
